// File: rtl/pan_pkg.sv
// Shared types and helpers for the PAN ingest / Luhn front end.
package pan_pkg;

    typedef enum logic [1:0] {
        PAN_IDLE    = 2'd0,
        PAN_COLLECT = 2'd1,
        PAN_DONE    = 2'd2,
        PAN_HOLD    = 2'd3
    } pan_state_e;

    localparam int          PAN_MIN_LEN  = 12;
    localparam int          PAN_MAX_LEN  = 19;
    localparam logic [15:0] PREFIX_EMPTY = 16'hFFFF;

    // Luhn doubling with digit-sum folded in; non-BCD codes contribute nothing.
    function automatic logic [3:0] luhn_dbl(input logic [3:0] d);
        logic [3:0] r;
        case (d)
            4'd0:    r = 4'd0;
            4'd1:    r = 4'd2;
            4'd2:    r = 4'd4;
            4'd3:    r = 4'd6;
            4'd4:    r = 4'd8;
            4'd5:    r = 4'd1;
            4'd6:    r = 4'd3;
            4'd7:    r = 4'd5;
            4'd8:    r = 4'd7;
            4'd9:    r = 4'd9;
            default: r = 4'd0;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] add_mod10(input logic [3:0] a, input logic [3:0] b);
        logic [4:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 5'd10) begin
            s = s - 5'd10;
        end
        return s[3:0];
    endfunction

endpackage

// File: rtl/pan_digit_ingest_luhn_accum.sv
// Dual-parity Luhn accumulator: one sum assumes even length, the other odd length.
module luhn_accum
    import pan_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic [3:0] digit,
    input  logic       idx_odd,
    output logic [3:0] sum_e,
    output logic [3:0] sum_o,
    output logic       bcd_err
);

    logic [3:0] sum_e_q;
    logic [3:0] sum_o_q;
    logic [3:0] plain;
    logic [3:0] dbl;

    // Sums are presented including the beat currently offered, so the parent
    // can register a verdict on the same edge that accepts the final digit.
    always_comb begin
        plain   = (digit > 4'd9) ? 4'd0 : digit;
        dbl     = luhn_dbl(digit);
        sum_e   = sum_e_q;
        sum_o   = sum_o_q;
        bcd_err = 1'b0;
        if (clr) begin
            sum_e = 4'd0;
            sum_o = 4'd0;
        end else if (en) begin
            sum_e   = add_mod10(sum_e_q, idx_odd ? plain : dbl);
            sum_o   = add_mod10(sum_o_q, idx_odd ? dbl : plain);
            bcd_err = (digit > 4'd9);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_e_q <= 4'd0;
            sum_o_q <= 4'd0;
        end else begin
            sum_e_q <= sum_e;
            sum_o_q <= sum_o;
        end
    end

endmodule

// File: rtl/pan_digit_ingest_luhn.sv
// PAN digit ingest: prefix capture, length tracking and incremental Luhn verdict.
module pan_digit_ingest_luhn
    import pan_pkg::*;
#(
    parameter int MIN_LEN = PAN_MIN_LEN,
    parameter int MAX_LEN = PAN_MAX_LEN
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        digit_valid,
    input  logic [3:0]  digit,
    input  logic        digit_last,
    output logic        digit_ready,
    output logic [15:0] prefix4_bcd,
    output logic        card_done,
    output logic        luhn_valid,
    output logic [4:0]  pan_len,
    output logic        err_bcd,
    output logic        err_len
);

    localparam logic [1:0] IDLE    = PAN_IDLE;
    localparam logic [1:0] COLLECT = PAN_COLLECT;
    localparam logic [1:0] DONE    = PAN_DONE;
    localparam logic [1:0] HOLD    = PAN_HOLD;

    logic [1:0] state;
    logic       accept;
    logic       in_range;
    logic [4:0] len_nxt;
    logic       err_bcd_nxt;
    logic       err_len_nxt;
    logic       too_short;
    logic       luhn_pass;
    logic [3:0] final_sum;
    logic [3:0] sum_e;
    logic [3:0] sum_o;
    logic       bcd_err;

    assign digit_ready = (state == COLLECT) && !start;
    assign accept      = digit_valid && digit_ready;
    assign in_range    = (pan_len < 5'(MAX_LEN));

    luhn_accum u_accum (
        .clk     (clk),
        .rst     (rst),
        .clr     (start),
        .en      (accept && in_range),
        .digit   (digit),
        .idx_odd (pan_len[0]),
        .sum_e   (sum_e),
        .sum_o   (sum_o),
        .bcd_err (bcd_err)
    );

    // Digits beyond MAX_LEN leave the sums alone and only raise err_len.
    always_comb begin
        len_nxt     = (accept && in_range) ? pan_len + 5'd1 : pan_len;
        err_bcd_nxt = err_bcd | bcd_err;
        err_len_nxt = err_len | (accept && !in_range);
        too_short   = (len_nxt < 5'(MIN_LEN));
        final_sum   = len_nxt[0] ? sum_o : sum_e;
        luhn_pass   = (final_sum == 4'd0) && !err_bcd_nxt && !err_len_nxt && !too_short;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            prefix4_bcd <= PREFIX_EMPTY;
            card_done   <= 1'b0;
            luhn_valid  <= 1'b0;
            pan_len     <= 5'd0;
            err_bcd     <= 1'b0;
            err_len     <= 1'b0;
        end else if (start) begin
            state       <= COLLECT;
            prefix4_bcd <= PREFIX_EMPTY;
            card_done   <= 1'b0;
            luhn_valid  <= 1'b0;
            pan_len     <= 5'd0;
            err_bcd     <= 1'b0;
            err_len     <= 1'b0;
        end else begin
            card_done <= 1'b0;
            case (state)
                COLLECT: begin
                    if (accept) begin
                        if (pan_len < 5'd4) begin
                            prefix4_bcd[{pan_len[1:0], 2'b00} +: 4] <= digit;
                        end
                        pan_len <= len_nxt;
                        err_bcd <= err_bcd_nxt;
                        err_len <= err_len_nxt;
                        if (digit_last) begin
                            state      <= DONE;
                            card_done  <= 1'b1;
                            luhn_valid <= luhn_pass;
                            err_len    <= err_len_nxt | too_short;
                        end
                    end
                end
                DONE:    state <= HOLD;
                default: state <= state;
            endcase
        end
    end

endmodule
